// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate extender: combinational format decode feeding
// a registered output stage backed by a one-entry skid register.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic            sign;
  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;

  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             main_illegal;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_illegal;

  logic accept;
  logic pop;

  assign sign = in_instr[31];

  always_comb begin
    ext_imm     = '0;
    ext_illegal = 1'b0;
    case (in_imm_src)
      3'b000: ext_imm = {{(XLEN-12){sign}}, in_instr[31:20]};
      3'b001: ext_imm = {{(XLEN-12){sign}}, in_instr[31:25], in_instr[11:7]};
      3'b010: ext_imm = {{(XLEN-12){sign}}, in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0};
      // Replicating the sign over XLEN-31 bits covers bit 31 and, for RV64, bits 63:32.
      3'b011: ext_imm = {{(XLEN-31){sign}}, in_instr[30:12], 12'b0};
      3'b100: ext_imm = {{(XLEN-20){sign}}, in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
      3'b101: ext_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
      3'b110: ext_imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, in_instr[25:20]}
                                     : {{(XLEN-5){1'b0}}, in_instr[24:20]};
      default: ext_illegal = 1'b1;
    endcase
  end

  assign in_ready    = ~skid_valid;
  assign accept      = in_valid & in_ready;
  assign pop         = main_valid & out_ready;
  assign out_valid   = main_valid;
  assign out_imm     = main_imm;
  assign out_tag     = main_tag;
  assign out_illegal = main_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid   <= 1'b0;
      main_imm     <= '0;
      main_tag     <= '0;
      main_illegal <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // FULL: input side is stalled, so only a pop can move data.
      if (pop) begin
        main_imm     <= skid_imm;
        main_tag     <= skid_tag;
        main_illegal <= skid_illegal;
        skid_valid   <= 1'b0;
      end
    end else if (main_valid && !pop) begin
      if (accept) begin
        skid_imm     <= ext_imm;
        skid_tag     <= in_tag;
        skid_illegal <= ext_illegal;
        skid_valid   <= 1'b1;
      end
    end else begin
      // Main stage is empty or draining this edge: reload it directly.
      main_valid <= accept;
      if (accept) begin
        main_imm     <= ext_imm;
        main_tag     <= in_tag;
        main_illegal <= ext_illegal;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: RV32 and RV64 instances share one stimulus stream and are
// checked against an arithmetic reference model of the immediate formats.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:7] in_instr;
  logic [2:0]  in_imm_src;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        use_exp = 1'b0;
  logic [31:0] exp32 = '0;
  logic [63:0] exp64 = '0;
  logic        disc = 1'b0;
  logic        rand_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Immediate value as the ISA defines it, built from signed field values.
  function automatic logic [63:0] model(input logic [31:0] ins, input logic [2:0] src,
                                        input int xlen);
    longint v;
    case (src)
      3'd0: v = longint'($signed(ins[31:20]));
      3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
      3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'd3: v = longint'($signed(ins)) & ~longint'(64'hFFF);
      3'd4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'd5: v = longint'(ins[19:15]);
      3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    return (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  // Push side: record every accepted transfer; a flush empties the model.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (flush) begin
          sb.delete();
          disc = 1'b1;
        end else if (in_valid && in_ready32) begin
          exp_t e;
          logic [63:0] m32;
          m32     = model({in_instr, 7'b0}, in_imm_src, 32);
          e.imm32 = use_exp ? exp32 : m32[31:0];
          e.imm64 = use_exp ? exp64 : model({in_instr, 7'b0}, in_imm_src, 64);
          e.tag   = in_tag;
          e.ill   = (in_imm_src == 3'b111);
          sb.push_back(e);
        end
      end
    end
  end

  // Monitor: compare popped entries and check held outputs stay stable.
  initial begin
    logic        hold_valid;
    logic [31:0] h_imm32, h_tag;
    logic [63:0] h_imm64;
    logic        h_ill;
    hold_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_valid && !disc) begin
          check("hold_valid", {63'b0, out_valid32}, 64'd1);
          check("hold_imm32", {32'b0, out_imm32}, {32'b0, h_imm32});
          check("hold_imm64", out_imm64, h_imm64);
          check("hold_tag", {32'b0, out_tag32}, {32'b0, h_tag});
          check("hold_ill", {63'b0, out_illegal32}, {63'b0, h_ill});
        end
        disc = 1'b0;
        hold_valid = out_valid32 && !out_ready;
        h_imm32 = out_imm32; h_imm64 = out_imm64; h_tag = out_tag32; h_ill = out_illegal32;
        check("valid_match", {63'b0, out_valid64}, {63'b0, out_valid32});
        check("ready_match", {63'b0, in_ready64}, {63'b0, in_ready32});
        if (out_valid32 && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop actual_tag=%h required=none", out_tag32);
          end else begin
            exp_t e;
            e = sb.pop_front();
            $display("pop tag=%h imm32=%h imm64=%h ill=%0d", out_tag32, out_imm32, out_imm64,
                     out_illegal32);
            check("imm32", {32'b0, out_imm32}, {32'b0, e.imm32});
            check("imm64", out_imm64, e.imm64);
            check("tag32", {32'b0, out_tag32}, {32'b0, e.tag});
            check("tag64", {32'b0, out_tag64}, {32'b0, e.tag});
            check("ill32", {63'b0, out_illegal32}, {63'b0, e.ill});
            check("ill64", {63'b0, out_illegal64}, {63'b0, e.ill});
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted it.
  task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag,
                      input logic dir, input logic [31:0] e32, input logic [63:0] e64);
    logic acc;
    int   n;
    n = 0;
    in_valid = 1'b1; in_instr = ins[31:7]; in_imm_src = src; in_tag = tag;
    use_exp = dir; exp32 = e32; exp64 = e64;
    do begin
      acc = in_ready32;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept tag=%h", tag);
    end
    in_valid = 1'b0;
    use_exp = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      cycles(1);
      n++;
    end
    cycles(2);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_imm_src = '0;
    in_tag = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", {63'b0, out_valid32}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready32}, 64'd1);
    check("rst_out_imm", out_imm64, 64'd0);
    check("rst_out_tag", {32'b0, out_tag32}, 64'd0);
    check("rst_out_ill", {63'b0, out_illegal32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);

    // Directed formats with fixed expected values.
    out_ready = 1'b1;
    send(32'hFFF00093, 3'b000, 32'hA001, 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    send(32'hFE000EE3, 3'b010, 32'hA002, 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    send(32'h123452B7, 3'b011, 32'hA003, 1'b1, 32'h12345000, 64'h0000000012345000);
    send(32'h001000EF, 3'b100, 32'hA004, 1'b1, 32'h00000800, 64'h0000000000000800);
    send(32'h800002B7, 3'b011, 32'hA005, 1'b1, 32'h80000000, 64'hFFFFFFFF80000000);
    send(32'hDEADBEEF, 3'b111, 32'hA006, 1'b1, 32'h00000000, 64'h0000000000000000);
    send(32'h000F8073, 3'b101, 32'hA007, 1'b1, 32'h0000001F, 64'h000000000000001F);
    send(32'h03F00013, 3'b110, 32'hA008, 1'b1, 32'h0000001F, 64'h000000000000003F);
    drain();

    // Backpressure: two entries fill main+skid, the third waits upstream.
    out_ready = 1'b0;
    send(32'h00500093, 3'b000, 32'h1, 1'b0, '0, '0);
    send(32'h00A12023, 3'b001, 32'h2, 1'b0, '0, '0);
    check("full_in_ready", {63'b0, in_ready32}, 64'd0);
    in_valid = 1'b1; in_instr = 25'h1ABCDE; in_imm_src = 3'b011; in_tag = 32'h3;
    cycles(3);
    check("full_hold_ready", {63'b0, in_ready32}, 64'd0);
    check("full_head_tag", {32'b0, out_tag32}, 64'd1);
    out_ready = 1'b1;
    send({25'h1ABCDE, 7'b0}, 3'b011, 32'h3, 1'b0, '0, '0);
    drain();
    check("bp_in_ready", {63'b0, in_ready32}, 64'd1);

    // Flush from FULL with a stalled input, then from ONE with a live accept.
    out_ready = 1'b0;
    send(32'h12300093, 3'b000, 32'hF1, 1'b0, '0, '0);
    send(32'h45600093, 3'b000, 32'hF2, 1'b0, '0, '0);
    in_valid = 1'b1; in_tag = 32'hF3; flush = 1'b1;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full_valid", {63'b0, out_valid32}, 64'd0);
    check("flush_full_ready", {63'b0, in_ready32}, 64'd1);
    send(32'h78900093, 3'b000, 32'hF4, 1'b0, '0, '0);
    in_valid = 1'b1; in_tag = 32'hF5; flush = 1'b1;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    cycles(3);
    check("flush_drop_valid", {63'b0, out_valid32}, 64'd0);
    check("flush_drop_valid64", {63'b0, out_valid64}, 64'd0);
    send(32'hABC00093, 3'b000, 32'hF6, 1'b0, '0, '0);
    drain();

    // Asynchronous reset mid-stream, asserted away from any clock edge.
    out_ready = 1'b0;
    send(32'h11100093, 3'b000, 32'hE1, 1'b0, '0, '0);
    send(32'h22200093, 3'b000, 32'hE2, 1'b0, '0, '0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    disc = 1'b1;
    #1;
    check("arst_out_valid", {63'b0, out_valid32}, 64'd0);
    check("arst_out_valid64", {63'b0, out_valid64}, 64'd0);
    check("arst_in_ready", {63'b0, in_ready32}, 64'd1);
    check("arst_out_tag", {32'b0, out_tag32}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    out_ready = 1'b1;
    send(32'h33300093, 3'b000, 32'hE3, 1'b0, '0, '0);
    drain();

    // Randomised traffic with random backpressure and idle gaps.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) cycles(1);
          send($urandom, 3'($urandom_range(0, 7)), $urandom, 1'b0, '0, '0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          cycles(1);
        end
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
